coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/vm_pkg.sv | 28 ++
 rtl/sensor_debounce.sv | 49 ++++
 rtl/coin_acceptor.sv | 193 +++++++++++++++++++
 tb/tb_coin_acceptor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the coin acceptor.
//   acc_state_t        : acceptor FSM state encoding
//   COIN_2C / COIN_10C : coin value encodings carried on coin_val and in the FIFO
//   DEF_*              : default debounce length and pulse-width thresholds (cycles)
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEASURE  = 2'd1,
        ST_CLASSIFY = 2'd2,
        ST_JAM      = 2'd3
    } acc_state_t;

    localparam logic COIN_2C  = 1'b0;
    localparam logic COIN_10C = 1'b1;

    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_TWO_MIN      = 8;
    localparam int DEF_TWO_MAX      = 15;
    localparam int DEF_TEN_MIN      = 20;
    localparam int DEF_TEN_MAX      = 31;
    localparam int DEF_JAM_CYC      = 63;
    localparam int DEF_FIFO_DEPTH   = 4;

    // Width counter is 6 bits; JAM_CYC must fit in it.
    localparam int WIDTH_BITS = 6;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a debouncer for the coin-slot sensor.
//   clk       : rising-edge clock
//   reset     : synchronous, active-high
//   sensor_in : raw asynchronous sensor level
//   level     : debounced level; follows the synchronised level only after it
//               has held a new value for DEBOUNCE_CYC consecutive cycles, so a
//               pulse of W >= DEBOUNCE_CYC cycles comes out W cycles wide.
module sensor_debounce
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_in,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= sensor_in;
            sync2 <= sync1;
            // cnt holds how many consecutive cycles sync2 has disagreed with
            // level; the DEBOUNCE_CYC-th disagreement flips the level.
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: measures the debounced sensor pulse width, classifies the
// coin as 2-cent or 10-cent, buffers accepted coins in a small FIFO and hands
// them to the vending FSM one per cycle while accept_en is high.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   sensor_in    : raw coin-slot sensor, high while a coin occludes it
//   accept_en    : downstream can take a coin this cycle
//   coin_in_en   : registered one-cycle strobe, one coin delivered
//   coin_val     : value of the delivered coin (COIN_2C / COIN_10C)
//   coin_reject  : registered one-cycle pulse, coin sent to the return chute
//   jam          : high while the FSM sits in JAM
//   fifo_full    : FIFO holds FIFO_DEPTH coins
//   reject_cnt   : saturating count of rejected coins
// The FSM state is kept in the signal 'state' for checkers to bind to.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int TWO_MIN      = DEF_TWO_MIN,
    parameter int TWO_MAX      = DEF_TWO_MAX,
    parameter int TEN_MIN      = DEF_TEN_MIN,
    parameter int TEN_MAX      = DEF_TEN_MAX,
    parameter int JAM_CYC      = DEF_JAM_CYC,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_in,
    input  logic       accept_en,
    output logic       coin_in_en,
    output logic       coin_val,
    output logic       coin_reject,
    output logic       jam,
    output logic       fifo_full,
    output logic [7:0] reject_cnt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [WIDTH_BITS-1:0] TWO_MIN_W = WIDTH_BITS'(TWO_MIN);
    localparam logic [WIDTH_BITS-1:0] TWO_MAX_W = WIDTH_BITS'(TWO_MAX);
    localparam logic [WIDTH_BITS-1:0] TEN_MIN_W = WIDTH_BITS'(TEN_MIN);
    localparam logic [WIDTH_BITS-1:0] TEN_MAX_W = WIDTH_BITS'(TEN_MAX);
    localparam logic [WIDTH_BITS-1:0] JAM_W     = WIDTH_BITS'(JAM_CYC);

    // ---------------- sensor conditioning ----------------
    logic deb;
    logic deb_q;
    logic rise;
    logic fall;

    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sensor_debounce (
        .clk       (clk),
        .reset     (reset),
        .sensor_in (sensor_in),
        .level     (deb)
    );

    always_ff @(posedge clk) begin
        if (reset) deb_q <= 1'b0;
        else       deb_q <= deb;
    end

    assign rise = deb & ~deb_q;
    assign fall = ~deb & deb_q;

    // ---------------- FIFO ----------------
    logic          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          push;
    logic          push_val;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = accept_en & ~empty;
    assign fifo_full = full;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            coin_in_en <= 1'b0;
            coin_val   <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            coin_in_en <= pop;
            coin_val   <= pop ? mem[rd_ptr] : 1'b0;
        end
    end

    // ---------------- FSM ----------------
    acc_state_t            state;
    acc_state_t            state_next;
    logic [WIDTH_BITS-1:0] width;
    logic [WIDTH_BITS-1:0] width_next;
    logic                  reject_next;
    logic                  is_two;
    logic                  is_ten;

    assign is_two = (width >= TWO_MIN_W) && (width <= TWO_MAX_W);
    assign is_ten = (width >= TEN_MIN_W) && (width <= TEN_MAX_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            width       <= '0;
            coin_reject <= 1'b0;
            reject_cnt  <= 8'd0;
        end else begin
            state       <= state_next;
            width       <= width_next;
            coin_reject <= reject_next;
            if (reject_next && reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next  = state;
        width_next  = width;
        push        = 1'b0;
        push_val    = COIN_2C;
        reject_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_next = ST_MEASURE;
                    width_next = WIDTH_BITS'(1);
                end
            end
            ST_MEASURE: begin
                // A falling level ends the pulse; reaching JAM_W stops the
                // counter there so it can never wrap.
                if (!deb) begin
                    state_next = ST_CLASSIFY;
                end else if (width == JAM_W) begin
                    state_next = ST_JAM;
                end else begin
                    width_next = width + 1'b1;
                end
            end
            ST_CLASSIFY: begin
                state_next = ST_IDLE;
                width_next = '0;
                if (is_two || is_ten) begin
                    // A pop in this cycle frees a slot, so a full FIFO can
                    // still take the coin.
                    if (!full || pop) begin
                        push     = 1'b1;
                        push_val = is_ten ? COIN_10C : COIN_2C;
                    end else begin
                        reject_next = 1'b1;
                    end
                end else begin
                    reject_next = 1'b1;
                end
            end
            ST_JAM: begin
                if (fall) begin
                    state_next  = ST_IDLE;
                    width_next  = '0;
                    reject_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                width_next = '0;
            end
        endcase
    end

    assign jam = (state == ST_JAM);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor. Pulse timing reference: a pulse task is
// entered just after a rising edge, raises sensor_in, and numbers the
// following edges 1, 2, ... With DEBOUNCE_CYC=4 a W-cycle pulse yields
// coin_in_en after edge W+9 (accept_en high) or coin_reject after edge W+8.
module tb_coin_acceptor;

    logic       clk;
    logic       reset;
    logic       sensor_in;
    logic       accept_en;
    logic       coin_in_en;
    logic       coin_val;
    logic       coin_reject;
    logic       jam;
    logic       fifo_full;
    logic [7:0] reject_cnt;

    coin_acceptor dut (
        .clk         (clk),
        .reset       (reset),
        .sensor_in   (sensor_in),
        .accept_en   (accept_en),
        .coin_in_en  (coin_in_en),
        .coin_val    (coin_val),
        .coin_reject (coin_reject),
        .jam         (jam),
        .fifo_full   (fifo_full),
        .reject_cnt  (reject_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor (sole writer of the observation record) ----------------
    logic got_val [1024];
    int   got_n    = 0;
    int   rej_seen = 0;

    always @(negedge clk) begin
        if (coin_in_en) begin
            got_val[got_n] = coin_val;
            got_n = got_n + 1;
        end
        if (coin_reject) rej_seen = rej_seen + 1;
    end

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int got_rd    = 0;
    int n_checks  = 0;
    int n_fail    = 0;
    int exp_rcnt  = 0;
    int first_coin;
    int first_rej;
    int first_jam;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_coins(input string name);
        logic [0:0] e;
        check({name, " count"}, got_n - got_rd, exp_q.size());
        while (got_rd < got_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, " value"}, int'(got_val[got_rd]), int'(e));
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_n;
    endtask

    // ---------------- driver ----------------
    // Entered just after a rising edge. Drives a w-cycle pulse, optionally
    // raises accept_en after edge raise_at, and records the first edge at
    // which each output event is seen.
    task automatic pulse(input int w, input int raise_at);
        first_coin = 0;
        first_rej  = 0;
        first_jam  = 0;
        sensor_in  = 1'b1;
        for (int n = 1; n <= w + 30; n++) begin
            @(posedge clk);
            #1;
            if (n == w) sensor_in = 1'b0;
            if (n == raise_at) accept_en = 1'b1;
            if (coin_in_en && first_coin == 0) first_coin = n;
            if (coin_reject && first_rej == 0) first_rej = n;
            if (jam && first_jam == 0) first_jam = n;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " coin_in_en"},  int'(coin_in_en),  0);
        check({tag, " coin_val"},    int'(coin_val),    0);
        check({tag, " coin_reject"}, int'(coin_reject), 0);
        check({tag, " jam"},         int'(jam),         0);
        check({tag, " fifo_full"},   int'(fifo_full),   0);
        check({tag, " reject_cnt"},  int'(reject_cnt),  0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int   width;
        int   exp_coins;
        logic exp_val;
        int   exp_rej;
        int   exp_edge;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int rb;
        int gb;
        string tag;

        vecs[0]  = '{10, 1, 1'b0, 0, 19};   // 2-cent
        vecs[1]  = '{25, 1, 1'b1, 0, 34};   // 10-cent
        vecs[2]  = '{3,  0, 1'b0, 0, 0};    // glitch, filtered
        vecs[3]  = '{17, 0, 1'b0, 1, 25};   // between bands
        vecs[4]  = '{8,  1, 1'b0, 0, 17};   // TWO_MIN
        vecs[5]  = '{15, 1, 1'b0, 0, 24};   // TWO_MAX
        vecs[6]  = '{7,  0, 1'b0, 1, 15};   // TWO_MIN-1
        vecs[7]  = '{16, 0, 1'b0, 1, 24};   // TWO_MAX+1
        vecs[8]  = '{20, 1, 1'b1, 0, 29};   // TEN_MIN
        vecs[9]  = '{31, 1, 1'b1, 0, 40};   // TEN_MAX
        vecs[10] = '{19, 0, 1'b0, 1, 27};   // TEN_MIN-1
        vecs[11] = '{32, 0, 1'b0, 1, 40};   // TEN_MAX+1

        // ---- reset ----
        reset     = 1'b1;
        sensor_in = 1'b0;
        accept_en = 1'b0;
        wait_cycles(3);
        check_all_zero("reset");
        reset     = 1'b0;
        accept_en = 1'b1;
        wait_cycles(5);

        // ---- table of single coins ----
        for (int i = 0; i < 12; i++) begin
            tag = $sformatf("vec%0d w%0d", i, vecs[i].width);
            rb  = rej_seen;
            if (vecs[i].exp_coins == 1) exp_q.push_back(vecs[i].exp_val);
            pulse(vecs[i].width, 0);
            compare_coins({tag, " coin"});
            check({tag, " rejects"}, rej_seen - rb, vecs[i].exp_rej);
            exp_rcnt += vecs[i].exp_rej;
            check({tag, " reject_cnt"}, int'(reject_cnt), exp_rcnt);
            check({tag, " event edge"}, (first_coin != 0) ? first_coin : first_rej, vecs[i].exp_edge);
        end

        // ---- FIFO fills, fifth coin rejected, order preserved ----
        accept_en = 1'b0;
        exp_q.push_back(1'b0); pulse(10, 0);
        exp_q.push_back(1'b1); pulse(25, 0);
        exp_q.push_back(1'b0); pulse(10, 0);
        check("fill3 fifo_full", int'(fifo_full), 0);
        exp_q.push_back(1'b1); pulse(25, 0);
        check("fill4 fifo_full", int'(fifo_full), 1);
        rb = rej_seen;
        pulse(10, 0);
        check("overflow rejects", rej_seen - rb, 1);
        exp_rcnt++;
        check("overflow reject_cnt", int'(reject_cnt), exp_rcnt);
        check("held coins", got_n - got_rd, 0);
        accept_en = 1'b1;
        wait_cycles(10);
        compare_coins("drain order");
        check("drained fifo_full", int'(fifo_full), 0);

        // ---- full FIFO with a pop in the CLASSIFY cycle accepts the push ----
        accept_en = 1'b0;
        exp_q.push_back(1'b1); pulse(25, 0);
        exp_q.push_back(1'b0); pulse(10, 0);
        exp_q.push_back(1'b1); pulse(25, 0);
        exp_q.push_back(1'b0); pulse(10, 0);
        check("refill fifo_full", int'(fifo_full), 1);
        exp_q.push_back(1'b1);
        rb = rej_seen;
        pulse(25, 32);   // CLASSIFY occupies the cycle after edge 25+7
        check("push+pop rejects", rej_seen - rb, 0);
        compare_coins("push+pop order");

        // ---- jam ----
        rb = rej_seen;
        pulse(100, 0);
        check("jam first edge", first_jam, 70);
        check("jam release reject edge", first_rej, 107);
        check("jam rejects", rej_seen - rb, 1);
        check("jam after release", int'(jam), 0);
        exp_rcnt++;
        check("jam reject_cnt", int'(reject_cnt), exp_rcnt);
        compare_coins("jam coins");

        // ---- reset mid-MEASURE with two coins buffered ----
        accept_en = 1'b0;
        pulse(10, 0);
        pulse(10, 0);
        sensor_in = 1'b1;
        wait_cycles(12);
        rb = rej_seen;
        gb = got_n;
        reset     = 1'b1;
        sensor_in = 1'b0;
        wait_cycles(1);
        check_all_zero("mid reset");
        wait_cycles(4);
        reset     = 1'b0;
        accept_en = 1'b1;
        wait_cycles(10);
        exp_rcnt = 0;
        check("post reset stray coins", got_n - gb, 0);
        check("post reset stray rejects", rej_seen - rb, 0);
        check("post reset fifo_full", int'(fifo_full), 0);
        check("post reset reject_cnt", int'(reject_cnt), 0);
        got_rd = got_n;
        exp_q.push_back(1'b0);
        pulse(10, 0);
        compare_coins("post reset coin");
        check("post reset coin edge", first_coin, 19);

        // ---- reject_cnt saturation ----
        rb = rej_seen;
        for (int i = 0; i < 260; i++) begin
            pulse(4, 0);
            exp_rcnt = (exp_rcnt < 255) ? exp_rcnt + 1 : 255;
        end
        check("sat rejects", rej_seen - rb, 260);
        check("sat reject_cnt", int'(reject_cnt), exp_rcnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
